// File: rtl/automate_job_sched.sv
// Round-robin scheduler time-sharing one automaton core among NREQ job requesters.
// Latency: gnt at cycle 0, core reset at 1, steps at 2..len+1, drain, done at len+3 when already idle.
// Backpressure: req is held until its gnt; done/result/err are not throttled, so the owner must take the done pulse.
module automate_job_sched #(
    parameter int NREQ    = 2,
    parameter int LEN_MAX = 8,
    parameter int LW      = 4,
    parameter int TMO     = 16
) (
    input  logic                    i_clk,
    input  logic                    i_res,
    input  logic [NREQ-1:0]         i_req,
    input  logic [NREQ*LEN_MAX-1:0] i_seq_x,
    input  logic [NREQ*LEN_MAX-1:0] i_seq_y,
    input  logic [NREQ*LW-1:0]      i_seq_len,
    output logic [NREQ-1:0]         o_gnt,
    output logic                    o_busy,
    output logic                    o_a_res,
    output logic                    o_a_en,
    output logic                    o_a_x,
    output logic                    o_a_y,
    input  logic [4:0]              i_a_t,
    input  logic                    i_a_idle,
    output logic [NREQ-1:0]         o_done,
    output logic [4:0]              o_result,
    output logic                    o_err
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DW = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_STEP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [PW-1:0]      r_rr;
    logic [PW-1:0]      r_owner;
    logic [PW-1:0]      w_pick;
    logic               w_found;
    logic [LEN_MAX-1:0] r_x;
    logic [LEN_MAX-1:0] r_y;
    logic [LEN_MAX-1:0] w_x_sh;
    logic [LEN_MAX-1:0] w_y_sh;
    logic [LW-1:0]      r_len;
    logic [LW-1:0]      r_idx;
    logic [LW-1:0]      w_len_in;
    logic [LW-1:0]      w_len_clamp;
    logic [DW-1:0]      r_dcnt;
    logic [4:0]         r_result;
    logic               r_err;
    logic               w_last_step;
    logic               w_drain_tmo;

    // First requester at or after the round-robin pointer, wrapping
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && i_req[(int'(r_rr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_pick  = PW'((int'(r_rr) + k) % NREQ);
            end
        end
    end

    assign w_len_in    = i_seq_len[int'(w_pick)*LW +: LW];
    assign w_len_clamp = (w_len_in > LW'(LEN_MAX)) ? LW'(LEN_MAX) : w_len_in;
    assign w_x_sh      = r_x >> r_idx;
    assign w_y_sh      = r_y >> r_idx;
    assign w_last_step = (r_idx == r_len - LW'(1));
    assign w_drain_tmo = (r_dcnt == DW'(TMO - 1));

    // State register
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and core/client strobes; reset forces the core into reset and silences everything else
    always_comb begin
        w_next  = r_state;
        o_gnt   = '0;
        o_done  = '0;
        o_busy  = 1'b0;
        o_a_res = i_res;
        o_a_en  = 1'b0;
        o_a_x   = 1'b0;
        o_a_y   = 1'b0;
        if (!i_res) begin
            o_busy = (r_state != S_IDLE);
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        o_gnt  = NREQ'(1) << w_pick;
                        w_next = S_CLR;
                    end
                end
                S_CLR: begin
                    o_a_res = 1'b1;
                    w_next  = (r_len == '0) ? S_DONE : S_STEP;
                end
                S_STEP: begin
                    o_a_en = 1'b1;
                    o_a_x  = w_x_sh[0];
                    o_a_y  = w_y_sh[0];
                    if (w_last_step) begin
                        w_next = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (i_a_idle) begin
                        w_next = S_DONE;
                    end else begin
                        o_a_en = 1'b1;
                        if (w_drain_tmo) begin
                            w_next = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    o_done = NREQ'(1) << r_owner;
                    w_next = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Job operands, step index, drain counter, result accumulation and timeout flag
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_rr     <= '0;
            r_owner  <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_len    <= '0;
            r_idx    <= '0;
            r_dcnt   <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_pick;
                        r_rr    <= PW'((int'(w_pick) + 1) % NREQ);
                        r_x     <= i_seq_x[int'(w_pick)*LEN_MAX +: LEN_MAX];
                        r_y     <= i_seq_y[int'(w_pick)*LEN_MAX +: LEN_MAX];
                        r_len   <= w_len_clamp;
                    end
                end
                S_CLR: begin
                    r_result <= '0;
                    r_err    <= 1'b0;
                    r_idx    <= '0;
                    r_dcnt   <= '0;
                end
                S_STEP: begin
                    r_result <= r_result | i_a_t;
                    r_idx    <= r_idx + LW'(1);
                end
                S_DRAIN: begin
                    if (!i_a_idle) begin
                        r_dcnt <= r_dcnt + DW'(1);
                        if (w_drain_tmo) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_result = r_result;
    assign o_err    = r_err;

endmodule

// File: tb/tb_automate_job_sched.sv
// Bench for automate_job_sched: small automaton core model, job-timeline reference model,
// per-cycle output compare, directed scenarios plus a randomized request phase.
module tb_automate_job_sched;
    localparam int NREQ    = 2;
    localparam int LEN_MAX = 8;
    localparam int LW      = 4;
    localparam int TMO     = 16;

    logic                    clk = 1'b0;
    logic                    res;
    logic [NREQ-1:0]         req;
    logic [NREQ*LEN_MAX-1:0] seq_x;
    logic [NREQ*LEN_MAX-1:0] seq_y;
    logic [NREQ*LW-1:0]      seq_len;
    logic [NREQ-1:0]         gnt;
    logic [NREQ-1:0]         done;
    logic                    busy, a_res, a_en, a_x, a_y, a_idle, err;
    logic [4:0]              a_t;
    logic [4:0]              result;

    always #5 clk = ~clk;

    automate_job_sched #(.NREQ(NREQ), .LEN_MAX(LEN_MAX), .LW(LW), .TMO(TMO)) dut (
        .i_clk(clk), .i_res(res), .i_req(req), .i_seq_x(seq_x), .i_seq_y(seq_y),
        .i_seq_len(seq_len), .o_gnt(gnt), .o_busy(busy), .o_a_res(a_res), .o_a_en(a_en),
        .o_a_x(a_x), .o_a_y(a_y), .i_a_t(a_t), .i_a_idle(a_idle), .o_done(done),
        .o_result(result), .o_err(err)
    );

    // ---------------- automaton core model ----------------
    logic [3:0] cs = 4'd0;
    bit         stuck = 1'b0;

    function automatic logic [3:0] core_next(input logic [3:0] s, input logic x, input logic y);
        logic [3:0] n;
        n = x ? (s + 4'd11) : (s >> 1);
        return n ^ (y ? 4'b1001 : 4'b0000);
    endfunction

    function automatic logic [4:0] core_t(input logic [3:0] s, input logic x, input logic y);
        return {s[3] ^ x, s[2] & y, s[1], s[0] | y, x};
    endfunction

    always @(posedge clk) begin
        if (a_res) cs <= 4'd0;
        else if (a_en) cs <= core_next(cs, a_x, a_y);
    end
    assign a_t    = core_t(cs, a_x, a_y);
    assign a_idle = !stuck && (cs == 4'd0);

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected outcome of a job: result word, drain step count, timeout flag
    task automatic predict(input logic [7:0] x, input logic [7:0] y, input int len, input bit stk,
                           output logic [4:0] r, output int d, output bit e);
        logic [3:0] s;
        s = 4'd0; r = 5'd0; d = 0; e = 1'b0;
        for (int i = 0; i < len; i++) begin
            r = r | core_t(s, x[i], y[i]);
            s = core_next(s, x[i], y[i]);
        end
        if (len != 0) begin
            while (stk || s != 4'd0) begin
                s = core_next(s, 1'b0, 1'b0);
                d++;
                if (d == TMO) begin
                    e = 1'b1;
                    break;
                end
            end
        end
    endtask

    // reference model state
    int              cyc = 0;
    bit              m_act = 1'b0;
    int              m_t0, m_end, m_len, m_d, m_own;
    int              m_rr = 0;
    logic [7:0]      m_x, m_y;
    logic [4:0]      m_res;
    bit              m_err;
    logic [NREQ-1:0] m_last_gnt = '0;

    // observations of the DUT used by directed checks
    int              gnt_cnt = 0, done_cnt = 0, last_gnt_cyc = 0, last_done_cyc = 0, en_cnt = 0;
    logic [NREQ-1:0] last_done = '0;
    logic [31:0]     ax_bits = '0;
    logic [NREQ-1:0] gnt_hist[$];
    int              gnt_cyc_hist[$];

    // Per-cycle compare of every DUT output against the job-timeline model
    always @(negedge clk) begin : cmp
        logic [NREQ-1:0] e_gnt, e_done;
        logic            e_busy, e_ares, e_en, e_x, e_y;
        int              off, own;
        cyc++;
        if (|gnt) begin
            gnt_cnt++; last_gnt_cyc = cyc; gnt_hist.push_back(gnt); gnt_cyc_hist.push_back(cyc);
            en_cnt = 0; ax_bits = '0;
        end
        if (a_en) begin
            if (en_cnt < 32) ax_bits[en_cnt] = a_x;
            en_cnt++;
        end
        if (|done) begin
            done_cnt++; last_done_cyc = cyc; last_done = done;
        end

        e_gnt = '0; e_done = '0; e_busy = 0; e_ares = 0; e_en = 0; e_x = 0; e_y = 0;
        if (res) begin
            e_ares = 1'b1; m_act = 1'b0; m_rr = 0;
        end else if (!m_act) begin
            own = -1;
            for (int k = 0; k < NREQ; k++)
                if (own < 0 && req[(m_rr + k) % NREQ]) own = (m_rr + k) % NREQ;
            if (own >= 0) begin
                e_gnt = NREQ'(1) << own;
                m_act = 1'b1; m_t0 = cyc; m_own = own; m_rr = (own + 1) % NREQ;
                m_x = seq_x[own*LEN_MAX +: LEN_MAX];
                m_y = seq_y[own*LEN_MAX +: LEN_MAX];
                m_len = int'(seq_len[own*LW +: LW]);
                if (m_len > LEN_MAX) m_len = LEN_MAX;
                predict(m_x, m_y, m_len, stuck, m_res, m_d, m_err);
                m_end = (m_len == 0) ? 2 : m_len + 2 + m_d + (m_err ? 0 : 1);
            end
        end else begin
            off = cyc - m_t0;
            e_busy = 1'b1;
            if (off == 1) e_ares = 1'b1;
            else if (off >= 2 && off < m_len + 2) begin
                e_en = 1'b1; e_x = m_x[off-2]; e_y = m_y[off-2];
            end else if (off >= m_len + 2 && off < m_len + 2 + m_d) e_en = 1'b1;
            if (off == m_end) begin
                e_done = NREQ'(1) << m_own;
                chk("result", result, m_res);
                chk("err", err, m_err);
                m_act = 1'b0;
            end
        end
        m_last_gnt = e_gnt;
        chk("gnt", gnt, e_gnt);
        chk("done", done, e_done);
        chk("busy", busy, e_busy);
        chk("a_res", a_res, e_ares);
        chk("a_en", a_en, e_en);
        chk("a_x", a_x, e_x);
        chk("a_y", a_y, e_y);
    end

    // ---------------- stimulus ----------------
    task automatic set_job(input int i, input logic [7:0] x, input logic [7:0] y, input logic [3:0] l);
        seq_x[i*LEN_MAX +: LEN_MAX] = x;
        seq_y[i*LEN_MAX +: LEN_MAX] = y;
        seq_len[i*LW +: LW] = l;
    endtask

    task automatic wait_gnt(input int budget);
        int g0; bit ok;
        g0 = gnt_cnt; ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(posedge clk);
            if (gnt_cnt != g0) ok = 1'b1;
        end
        chk("gnt_timeout", ok, 1);
    endtask

    task automatic wait_done(input int budget);
        int d0; bit ok;
        d0 = done_cnt; ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(posedge clk);
            if (done_cnt != d0) ok = 1'b1;
        end
        chk("done_timeout", ok, 1);
    endtask

    initial begin
        int g0, sz;
        res = 1'b1; req = '0; seq_x = '0; seq_y = '0; seq_len = '0;

        // reset held 3 cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", result, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_a_res", a_res, 1);
        chk("rst_a_en", a_en, 0);
        res = 1'b0;

        // single job, len 3, x=101, core idle right after the last step
        @(posedge clk); #1;
        set_job(0, 8'b0000_0101, 8'h00, 4'd3); req = 2'b01;
        wait_gnt(10); #1; req = '0;
        wait_done(40); #1;
        chk("B_latency", last_done_cyc - last_gnt_cyc, 6);
        chk("B_done", last_done, 2'b01);
        chk("B_result", result, 5'h17);
        chk("B_err", err, 0);
        chk("B_en_cycles", en_cnt, 3);
        chk("B_ax_seq", ax_bits[2:0], 3'b101);

        // both requesting for three jobs: alternating grants from a fresh pointer
        @(posedge clk); #1; res = 1'b1;
        @(posedge clk); #1; res = 1'b0;
        set_job(0, 8'h00, 8'h00, 4'd2); set_job(1, 8'h00, 8'h00, 4'd2); req = 2'b11;
        g0 = gnt_cnt;
        for (int n = 0; n < 80 && (gnt_cnt - g0) < 3; n++) @(posedge clk);
        #1; req = '0;
        chk("C_count", gnt_cnt - g0, 3);
        wait_done(40); #1;
        sz = gnt_hist.size();
        if (sz >= 3) begin
            chk("C_g1", gnt_hist[sz-3], 2'b01);
            chk("C_g2", gnt_hist[sz-2], 2'b10);
            chk("C_g3", gnt_hist[sz-1], 2'b01);
            chk("C_gap1", gnt_cyc_hist[sz-2] - gnt_cyc_hist[sz-3], 6);
            chk("C_gap2", gnt_cyc_hist[sz-1] - gnt_cyc_hist[sz-2], 6);
        end else begin
            chk("C_hist_size", sz, 3);
        end

        // zero-length job
        @(posedge clk); #1;
        set_job(1, 8'hFF, 8'hFF, 4'd0); req = 2'b10;
        wait_gnt(10); #1; req = '0;
        wait_done(10); #1;
        chk("D_latency", last_done_cyc - last_gnt_cyc, 2);
        chk("D_done", last_done, 2'b10);
        chk("D_en_cycles", en_cnt, 0);
        chk("D_result", result, 0);

        // core never reports idle: drain timeout
        @(posedge clk); #1;
        stuck = 1'b1; set_job(0, 8'h01, 8'h00, 4'd1); req = 2'b01;
        wait_gnt(10); #1; req = '0;
        wait_done(60); #1;
        chk("E_latency", last_done_cyc - last_gnt_cyc, 19);
        chk("E_en_cycles", en_cnt, 17);
        chk("E_err", err, 1);
        chk("E_result", result, 5'h11);
        stuck = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("E_err_hold", err, 1);
        set_job(1, 8'h00, 8'h00, 4'd1); req = 2'b10;
        wait_gnt(10); #1; req = '0;
        @(posedge clk); #1;
        chk("E_err_clr", err, 0);
        wait_done(20); #1;
        chk("E_err_next", err, 0);

        // reset during STEP idx=2 aborts the job silently
        @(posedge clk); #1;
        set_job(0, 8'($urandom), 8'($urandom), 4'd5); req = 2'b01;
        wait_gnt(10); #1; req = '0;
        repeat (3) @(posedge clk);
        #1; res = 1'b1; g0 = done_cnt;
        @(posedge clk); #1; res = 1'b0;
        chk("F_busy_after", busy, 0);
        chk("F_en_after", a_en, 0);
        repeat (8) @(posedge clk); #1;
        chk("F_no_done", done_cnt - g0, 0);
        set_job(0, 8'($urandom), 8'($urandom), 4'd4); req = 2'b01;
        wait_gnt(10); #1; req = '0;
        wait_done(40); #1;
        chk("F_fresh_done", last_done, 2'b01);

        // randomized requests, lengths 0..15 (lengths above LEN_MAX are clamped)
        for (int n = 0; n < 600; n++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req[i] = 1'b1;
                        set_job(i, 8'($urandom), 8'($urandom), 4'($urandom));
                    end
                end else if (m_last_gnt[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else set_job(i, 8'($urandom), 8'($urandom), 4'($urandom));
                end
            end
        end
        req = '0;
        for (int n = 0; n < 100 && (m_act || busy); n++) @(posedge clk);
        #1;
        chk("final_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
